clock_control_panel: RTL and testbench
======================================

Name: clock_control_panel

Overview:
Front-panel controller that drives the control side of the clock module's interface: stop, single_step and single_stepping.
- Turns raw operator switches and a CPU halt request into clean, glitch-free control signals.
- Issues one single_step pulse per button press, then waits for clk_out to complete a full cycle before accepting another press.
- Sits between the panel I/O pins and the clock module, in the clk_in domain.

Parameters:
DEBOUNCE_CYCLES, 10000, consecutive stable clk_in cycles needed to accept a new switch level (1 ms at 10 MHz).
STEP_PULSE_CYCLES, 4, width of the single_step pulse in clk_in cycles (minimum 1).
STEP_TIMEOUT_CYCLES, 200000, clk_in cycles to wait for the clk_out cycle before flagging a timeout.

Ports:
clk_in  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
stop_switch  input  1  raw, asynchronous panel STOP switch; high = stop
step_mode_switch  input  1  raw, asynchronous panel switch; high = single-step mode
step_button  input  1  raw, asynchronous panel STEP push-button; high = pressed
cpu_halt  input  1  one-cycle pulse from the CPU STP instruction, synchronous to clk_in
clk_out  input  1  feedback from the clock module output
stop  output  1  to clock module
single_step  output  1  to clock module
single_stepping  output  1  to clock module
halted  output  1  status LED: the halt latch is set
step_timeout  output  1  sticky flag: the last step saw no clk_out cycle
step_count  output  16  number of completed single steps; wraps at 0xFFFF to 0

Behaviour:
- Reset values: stop=1, single_step=0, single_stepping=0, halted=0, step_timeout=0, step_count=0, state=HALTED.
  - All debounced levels reset to 0.
  - The halt latch resets to 0.
- Input conditioning (each raw switch and the button):
  - Two-flop synchroniser, then a debouncer.
  - The debounced level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - Latency from a clean input edge to the debounced edge is 2+DEBOUNCE_CYCLES cycles.
- A step press is the rising edge of the debounced button.
- Halt latch:
  - Set by cpu_halt.
  - Cleared on the falling edge of the debounced stop_switch.
  - cpu_halt has priority when both occur in the same cycle.
  - halted = latch.
- halt_cond = debounced stop_switch OR halt latch.
- States (all outputs registered, one cycle after entering a state):
  - RUN: stop=0, single_stepping=0.
    - halt_cond → HALTED.
    - Debounced step_mode → STEP_IDLE.
  - HALTED: stop=1, single_stepping=0.
    - When halt_cond clears → STEP_IDLE if step_mode, else RUN.
  - STEP_IDLE: stop=0, single_stepping=1.
    - halt_cond → HALTED.
    - step_mode low → RUN.
    - Step press → STEP_PULSE; clears step_timeout and loads the pulse counter.
  - STEP_PULSE: single_step=1 for exactly STEP_PULSE_CYCLES cycles, then → STEP_WAIT.
  - STEP_WAIT: single_step=0.
    - Waits for a rising then a falling edge of clk_out (edges detected on registered clk_out).
    - On the falling edge: step_count += 1 → STEP_IDLE.
    - If STEP_TIMEOUT_CYCLES elapse from entry: step_timeout=1, step_count unchanged → STEP_IDLE.
- Priorities:
  - halt_cond forces HALTED from any state, including STEP_PULSE and STEP_WAIT.
    - single_step drops one cycle later.
    - The partial step is not counted.
  - A step_mode change during STEP_PULSE or STEP_WAIT is deferred until STEP_IDLE.
  - Step presses outside STEP_IDLE are discarded, not queued.
  - A button held down produces only one step.
- Invariant: stop and single_step are never high in the same cycle.
- Reset mid-operation returns everything to reset values on the next edge, whatever the state.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, STEP_PULSE_CYCLES=2, STEP_TIMEOUT_CYCLES=64. clk_out comes from an instanced clock module or a bench toggler.

1. Reset, then drop stop_switch with mode=0 → stop=0 exactly 7 cycles after the input edge (2 sync + 4 debounce + 1 registered state); single_stepping=0.
2. Bounce stop_switch high for 3 cycles then low → stop stays 0 throughout; debounced level unchanged.
3. Step mode with clk_out toggling → press the button 3 times:
   - single_step is high for exactly 2 cycles per press;
   - step_count reaches 3;
   - holding the button high for 100 cycles gives exactly one pulse.
4. Step mode with clk_out held at 0, then press → step_timeout=1 64 cycles after entering STEP_WAIT, step_count unchanged; the next press clears step_timeout.
5. Pulse cpu_halt in RUN → stop=1 and halted=1 on the next registered cycle. Then raise and lower stop_switch → halted=0 and stop=0, returning to RUN.
6. Assert stop_switch during STEP_PULSE → state HALTED, single_step=0 the next cycle, step_count unchanged. Assert reset in STEP_WAIT → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/clock_control_panel.sv
// Front-panel clock controller: conditions the panel switches and the CPU halt request
// into the stop / single_step / single_stepping controls for the clock module.
module clock_control_panel #(
    parameter int DEBOUNCE_CYCLES     = 10000,
    parameter int STEP_PULSE_CYCLES   = 4,
    parameter int STEP_TIMEOUT_CYCLES = 200000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        stop_switch,
    input  logic        step_mode_switch,
    input  logic        step_button,
    input  logic        cpu_halt,
    input  logic        clk_out,
    output logic        stop,
    output logic        single_step,
    output logic        single_stepping,
    output logic        halted,
    output logic        step_timeout,
    output logic [15:0] step_count
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PULSE_W = $clog2(STEP_PULSE_CYCLES + 1);
    localparam int TO_W    = $clog2(STEP_TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        RUN,
        HALTED,
        STEP_IDLE,
        STEP_PULSE,
        STEP_WAIT
    } state_t;

    state_t state;
    state_t next_state;

    // Bit 0 = stop switch, bit 1 = step mode switch, bit 2 = step button.
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      deb;
    logic [DB_W-1:0] db_cnt [3];

    logic deb_stop_q;
    logic deb_button_q;
    logic halt_latch;
    logic clk_out_q;
    logic clk_out_q2;
    logic seen_rise;

    logic [PULSE_W-1:0] pulse_cnt;
    logic [TO_W-1:0]    wait_cnt;

    logic step_mode;
    logic step_press;
    logic stop_fall;
    logic halt_cond;
    logic halt_now;
    logic clk_rise;
    logic clk_fall;
    logic step_done;
    logic timeout_hit;

    assign raw        = {step_button, step_mode_switch, stop_switch};
    assign step_mode  = deb[1];
    assign step_press = deb[2] & ~deb_button_q;
    assign stop_fall  = ~deb[0] & deb_stop_q;
    assign halt_cond  = deb[0] | halt_latch;
    // cpu_halt also forces HALTED directly so stop rises in the same cycle as the latch.
    assign halt_now   = halt_cond | cpu_halt;
    assign clk_rise   = clk_out_q & ~clk_out_q2;
    assign clk_fall   = ~clk_out_q & clk_out_q2;
    assign halted     = halt_latch;

    // A level is accepted only after the synchronised input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            deb_stop_q   <= 1'b0;
            deb_button_q <= 1'b0;
            halt_latch   <= 1'b0;
            clk_out_q    <= 1'b0;
            clk_out_q2   <= 1'b0;
        end else begin
            deb_stop_q   <= deb[0];
            deb_button_q <= deb[2];
            clk_out_q    <= clk_out;
            clk_out_q2   <= clk_out_q;
            if (cpu_halt) begin
                halt_latch <= 1'b1;
            end else if (stop_fall) begin
                halt_latch <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= HALTED;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        step_done   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            RUN: begin
                if (halt_now) begin
                    next_state = HALTED;
                end else if (step_mode) begin
                    next_state = STEP_IDLE;
                end
            end
            HALTED: begin
                if (!halt_now) begin
                    next_state = step_mode ? STEP_IDLE : RUN;
                end
            end
            STEP_IDLE: begin
                if (halt_now) begin
                    next_state = HALTED;
                end else if (!step_mode) begin
                    next_state = RUN;
                end else if (step_press) begin
                    next_state = STEP_PULSE;
                end
            end
            STEP_PULSE: begin
                if (halt_now) begin
                    next_state = HALTED;
                end else if (pulse_cnt == PULSE_W'(1)) begin
                    next_state = STEP_WAIT;
                end
            end
            STEP_WAIT: begin
                if (halt_now) begin
                    next_state = HALTED;
                end else if (seen_rise && clk_fall) begin
                    step_done  = 1'b1;
                    next_state = STEP_IDLE;
                end else if (wait_cnt == TO_W'(STEP_TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    next_state  = STEP_IDLE;
                end
            end
            default: next_state = HALTED;
        endcase
    end

    // Outputs are decoded from next_state so they change on the same edge as the state.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            stop            <= 1'b1;
            single_step     <= 1'b0;
            single_stepping <= 1'b0;
            step_timeout    <= 1'b0;
            step_count      <= 16'd0;
            pulse_cnt       <= '0;
            wait_cnt        <= '0;
            seen_rise       <= 1'b0;
        end else begin
            stop            <= (next_state == HALTED);
            single_step     <= (next_state == STEP_PULSE);
            single_stepping <= (next_state == STEP_IDLE) || (next_state == STEP_PULSE) ||
                               (next_state == STEP_WAIT);
            if (state == STEP_IDLE && next_state == STEP_PULSE) begin
                step_timeout <= 1'b0;
                pulse_cnt    <= PULSE_W'(STEP_PULSE_CYCLES);
            end else if (state == STEP_PULSE) begin
                pulse_cnt <= pulse_cnt - PULSE_W'(1);
            end
            if (next_state == STEP_WAIT && state != STEP_WAIT) begin
                wait_cnt  <= '0;
                seen_rise <= 1'b0;
            end else if (state == STEP_WAIT) begin
                wait_cnt <= wait_cnt + TO_W'(1);
                if (clk_rise) begin
                    seen_rise <= 1'b1;
                end
            end
            if (step_done) begin
                step_count <= step_count + 16'd1;
            end
            if (timeout_hit) begin
                step_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_control_panel.sv
// Directed bench for clock_control_panel with short debounce/pulse/timeout settings
// and a gated clk_out toggler standing in for the clock module.
module tb_clock_control_panel;

    logic        clk_in;
    logic        reset;
    logic        stop_switch;
    logic        step_mode_switch;
    logic        step_button;
    logic        cpu_halt;
    logic        clk_out;
    logic        stop;
    logic        single_step;
    logic        single_stepping;
    logic        halted;
    logic        step_timeout;
    logic [15:0] step_count;

    logic clk_run;
    int   tog_cnt;
    int   vectors;
    int   miscompares;
    int   pulses;
    logic prev_step;

    clock_control_panel #(
        .DEBOUNCE_CYCLES    (4),
        .STEP_PULSE_CYCLES  (2),
        .STEP_TIMEOUT_CYCLES(64)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .stop_switch     (stop_switch),
        .step_mode_switch(step_mode_switch),
        .step_button     (step_button),
        .cpu_halt        (cpu_halt),
        .clk_out         (clk_out),
        .stop            (stop),
        .single_step     (single_step),
        .single_stepping (single_stepping),
        .halted          (halted),
        .step_timeout    (step_timeout),
        .step_count      (step_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // clk_out toggles every 4 clk_in cycles while clk_run is set, otherwise held low.
    always @(posedge clk_in) begin
        #2;
        if (!clk_run) begin
            tog_cnt = 0;
            clk_out = 1'b0;
        end else begin
            tog_cnt = tog_cnt + 1;
            if (tog_cnt == 4) begin
                tog_cnt = 0;
                clk_out = ~clk_out;
            end
        end
    end

    always @(negedge clk_in) begin
        if (reset === 1'b0) begin
            vectors = vectors + 1;
            assert (!(stop === 1'b1 && single_step === 1'b1)) else begin
                miscompares = miscompares + 1;
                $error("[TB] FAIL stop_step_exclusive: observed stop=%b single_step=%b required not both 1",
                       stop, single_step);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic stop_v, input logic mode_v, input logic button_v);
        stop_switch      = stop_v;
        step_mode_switch = mode_v;
        step_button      = button_v;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk_run     = 1'b0;
        clk_out     = 1'b0;
        tog_cnt     = 0;
        cpu_halt    = 1'b0;
        reset       = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Reset values
        tick(3);
        checkOutput("reset_stop", 16'(stop), 16'd1);
        checkOutput("reset_single_step", 16'(single_step), 16'd0);
        checkOutput("reset_single_stepping", 16'(single_stepping), 16'd0);
        checkOutput("reset_halted", 16'(halted), 16'd0);
        checkOutput("reset_step_timeout", 16'(step_timeout), 16'd0);
        checkOutput("reset_step_count", step_count, 16'd0);
        reset = 1'b0;
        tick(12);
        checkOutput("switch_stop_held", 16'(stop), 16'd1);

        // Drop STOP with mode off: stop falls exactly 7 cycles after the input edge
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(6);
        checkOutput("stop_edge_minus1", 16'(stop), 16'd1);
        tick(1);
        checkOutput("stop_edge_7", 16'(stop), 16'd0);
        checkOutput("run_single_stepping", 16'(single_stepping), 16'd0);

        // 3-cycle bounce must not get through
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("bounce_stop", 16'(stop), 16'd0);
        end

        // Enter step mode with clk_out running
        clk_run = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick(6);
        checkOutput("mode_edge_minus1", 16'(single_stepping), 16'd0);
        tick(1);
        checkOutput("mode_edge_7", 16'(single_stepping), 16'd1);

        // Three presses, each a 2-cycle pulse and one counted step
        for (int p = 0; p < 3; p++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            tick(6);
            checkOutput("press_pre", 16'(single_step), 16'd0);
            tick(1);
            checkOutput("press_pulse1", 16'(single_step), 16'd1);
            tick(1);
            checkOutput("press_pulse2", 16'(single_step), 16'd1);
            tick(1);
            checkOutput("press_pulse_end", 16'(single_step), 16'd0);
            applyStimulus(1'b0, 1'b1, 1'b0);
            tick(30);
        end
        checkOutput("three_steps_count", step_count, 16'd3);

        // Held button gives one pulse
        pulses    = 0;
        prev_step = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 110; i++) begin
            if (i == 100) begin
                applyStimulus(1'b0, 1'b1, 1'b0);
            end
            tick(1);
            if (single_step === 1'b1 && prev_step === 1'b0) begin
                pulses = pulses + 1;
            end
            prev_step = single_step;
        end
        checkOutput("held_button_pulses", 16'(pulses), 16'd1);
        checkOutput("held_button_count", step_count, 16'd4);
        tick(10);

        // No clk_out activity: timeout 64 cycles after entering STEP_WAIT
        clk_run = 1'b0;
        tick(5);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(10);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick(62);
        checkOutput("timeout_pre", 16'(step_timeout), 16'd0);
        tick(1);
        checkOutput("timeout_set", 16'(step_timeout), 16'd1);
        checkOutput("timeout_count", step_count, 16'd4);
        tick(10);

        // Next press clears the flag; clk_out restarts and the step completes
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(6);
        checkOutput("timeout_still_set", 16'(step_timeout), 16'd1);
        tick(1);
        checkOutput("timeout_cleared", 16'(step_timeout), 16'd0);
        clk_run = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick(40);
        checkOutput("recovered_count", step_count, 16'd5);
        checkOutput("recovered_timeout", 16'(step_timeout), 16'd0);

        // cpu_halt in RUN, then cleared by a STOP raise/lower
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(10);
        checkOutput("run_stop", 16'(stop), 16'd0);
        checkOutput("run_stepping", 16'(single_stepping), 16'd0);
        cpu_halt = 1'b1;
        tick(1);
        cpu_halt = 1'b0;
        checkOutput("cpu_halt_stop", 16'(stop), 16'd1);
        checkOutput("cpu_halt_halted", 16'(halted), 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(10);
        checkOutput("halt_switch_up", 16'(halted), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(10);
        checkOutput("halt_cleared", 16'(halted), 16'd0);
        checkOutput("halt_cleared_stop", 16'(stop), 16'd0);

        // STOP arriving during STEP_PULSE aborts the step
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick(10);
        checkOutput("abort_mode", 16'(single_stepping), 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(6);
        checkOutput("abort_in_pulse", 16'(single_step), 16'd1);
        tick(1);
        checkOutput("abort_step_drop", 16'(single_step), 16'd0);
        checkOutput("abort_stop", 16'(stop), 16'd1);
        tick(30);
        checkOutput("abort_count", step_count, 16'd5);

        // Reset while parked in STEP_WAIT
        clk_run = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick(12);
        checkOutput("rewait_idle", 16'(single_stepping), 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(20);
        checkOutput("wait_step", 16'(single_step), 16'd0);
        checkOutput("wait_stop", 16'(stop), 16'd0);
        reset = 1'b1;
        tick(1);
        checkOutput("midreset_stop", 16'(stop), 16'd1);
        checkOutput("midreset_single_step", 16'(single_step), 16'd0);
        checkOutput("midreset_single_stepping", 16'(single_stepping), 16'd0);
        checkOutput("midreset_halted", 16'(halted), 16'd0);
        checkOutput("midreset_step_timeout", 16'(step_timeout), 16'd0);
        checkOutput("midreset_step_count", step_count, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
